// File: rtl/seq_divider.sv
// Restoring sequential divider for the SimpleRisc div/mod instructions.
// Signed operands are converted to magnitudes, divided one quotient bit per
// clock (MSB first), and the signs are reapplied in a single finishing cycle.
// Latency from the accepting edge to done is WIDTH+1 edges for every operand.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    // Counter wide enough to hold WIDTH-1 even for tiny WIDTH values.
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state_reg;
    // Dividend magnitude shifts out of the top while quotient bits shift in
    // at the bottom, so one register serves both roles.
    logic [WIDTH-1:0]   dq_reg;
    logic [WIDTH-1:0]   dvs_reg;
    // The kept partial remainder is always below the divisor magnitude, so
    // WIDTH bits suffice; the extra bit only exists in the shifted trial value.
    logic [WIDTH-1:0]   rem_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               sign_q_reg;
    logic               sign_r_reg;
    logic               zero_reg;
    logic [WIDTH-1:0]   quotient_reg;
    logic [WIDTH-1:0]   remainder_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               div_by_zero_reg;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     trial;

    // Operand magnitudes and the shift/trial-subtract datapath for one iteration.
    always_comb begin
        a_mag     = A[WIDTH-1] ? (~A + 1'b1) : A;
        b_mag     = B[WIDTH-1] ? (~B + 1'b1) : B;
        rem_shift = {rem_reg, dq_reg[WIDTH-1]};
        trial     = rem_shift - {1'b0, dvs_reg};
    end

    // Control FSM with registered outputs; datapath registers advance with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            dq_reg          <= '0;
            dvs_reg         <= '0;
            rem_reg         <= '0;
            cnt_reg         <= '0;
            sign_q_reg      <= 1'b0;
            sign_r_reg      <= 1'b0;
            zero_reg        <= 1'b0;
            quotient_reg    <= '0;
            remainder_reg   <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            div_by_zero_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        sign_q_reg <= A[WIDTH-1] ^ B[WIDTH-1];
                        sign_r_reg <= A[WIDTH-1];
                        zero_reg   <= (B == '0);
                        dq_reg     <= a_mag;
                        dvs_reg    <= b_mag;
                        rem_reg    <= '0;
                        cnt_reg    <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    // A negative trial (top bit set) means restore and record a 0.
                    dq_reg  <= {dq_reg[WIDTH-2:0], ~trial[WIDTH]};
                    rem_reg <= trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_ITER) begin
                        state_reg <= FINISH;
                    end
                end
                FINISH: begin
                    // With a zero divisor the remainder magnitude equals |A|,
                    // so reapplying the dividend sign returns A unchanged.
                    if (zero_reg) begin
                        quotient_reg <= '1;
                    end else begin
                        quotient_reg <= sign_q_reg ? (~dq_reg + 1'b1) : dq_reg;
                    end
                    remainder_reg   <= sign_r_reg ? (~rem_reg + 1'b1) : rem_reg;
                    div_by_zero_reg <= zero_reg;
                    done_reg        <= 1'b1;
                    busy_reg        <= 1'b0;
                    state_reg       <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Testbench for seq_divider: directed corner cases, handshake and reset
// scenarios, then random operands, all compared against a signed-arithmetic
// reference model.
module tb_seq_divider;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int checks;
    int errors;

    logic [31:0] exp_q;
    logic [31:0] exp_r;
    logic        exp_z;

    seq_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .A           (a_in),
        .B           (b_in),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s differs", tag);
        end
    endtask

    // Reference: signed division truncating toward zero, remainder follows dividend.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        z  = (b == 32'd0);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endtask

    // Called at a negedge: presents operands with start, lets the accepting
    // edge pass, then scrambles the inputs to prove they are not re-sampled.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        model(a, b, exp_q, exp_r, exp_z);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    // Waits for done (bounded), optionally re-pulsing start mid-run, then
    // checks latency and results. Returns at the negedge where done is high.
    task automatic await_result(input string name, input bit poke);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (poke && n == 5) begin
                start = 1'b1;
                a_in  = 32'd999;
                b_in  = 32'd3;
            end else if (poke && n == 6) begin
                start = 1'b0;
            end
        end
        check({name, "_latency"}, n, 32'd33);
        check({name, "_quotient"}, quotient, exp_q);
        check({name, "_remainder"}, remainder, exp_r);
        check({name, "_dbz"}, {31'd0, div_by_zero}, {31'd0, exp_z});
        check({name, "_busy_low"}, {31'd0, busy}, 32'd0);
        $display("op %s A/B done after %0d cycles q=%h r=%h dbz=%0d", name, n, quotient, remainder, div_by_zero);
    endtask

    // One cycle after done: pulse has ended and results hold.
    task automatic check_hold(input string name);
        @(posedge clk);
        @(negedge clk);
        check({name, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({name, "_q_hold"}, quotient, exp_q);
        check({name, "_r_hold"}, remainder, exp_r);
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b);
        issue(a, b);
        await_result(name, 1'b0);
        check_hold(name);
    endtask

    initial begin
        int seen_done;
        logic [31:0] ra;
        logic [31:0] rb;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        a_in   = 32'd0;
        b_in   = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("pos_pos", 32'd100, 32'd7);
        run_op("neg_pos", -32'sd100, 32'd7);
        run_op("pos_neg", 32'd100, -32'sd7);
        run_op("neg_neg", -32'sd100, -32'sd7);
        run_op("overflow", 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("max_by_1", 32'h7FFF_FFFF, 32'd1);
        run_op("small", 32'd5, 32'd9);
        run_op("div_zero", 32'd1234, 32'd0);
        run_op("neg_div_zero", 32'h8000_0000, 32'd0);
        run_op("clear_dbz", 32'd100, 32'd7);

        // start re-pulsed mid-run with other operands must be ignored.
        issue(32'd500, 32'd13);
        await_result("ignored_restart", 1'b1);
        check_hold("ignored_restart");

        // start accepted on the done cycle itself.
        issue(32'd77, 32'd5);
        await_result("chain_first", 1'b0);
        issue(-32'sd77, 32'd5);
        check("chain_done_pulse", {31'd0, done}, 32'd0);
        await_result("chain_second", 1'b0);
        check_hold("chain_second");

        // Reset partway through RUN aborts without a done pulse.
        issue(32'd4000, 32'd3);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_quotient", quotient, 32'd0);
        check("midrst_remainder", remainder, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
        seen_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
        end
        check("midrst_no_done", seen_done, 32'd0);
        run_op("after_reset", 32'd100, 32'd7);

        // Random operands with biased divisor choices.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = $urandom;
                1: rb = $urandom_range(1, 40);
                2: rb = -$urandom_range(1, 40);
                3: rb = 32'd0;
                default: begin
                    rb = $urandom_range(1, 1000);
                    ra = 32'h8000_0000;
                end
            endcase
            run_op($sformatf("rand%0d", i), ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle restoring divider for the SimpleRisc `div` and `mod` instructions.
- Divides by repeated trial subtraction, one quotient bit per clock.
- Sits beside the combinational ALU in the execute stage. The pipeline stalls on `busy` and captures `quotient` and `remainder` when `done` pulses.
- Operands are signed two's complement. The quotient truncates toward zero.

Parameters:
- WIDTH, 32, operand and result width in bits. The iteration count equals WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a division; sampled only while idle
- A  input  WIDTH  dividend, signed
- B  input  WIDTH  divisor, signed
- quotient  output  WIDTH  signed quotient; holds until the next completion
- remainder  output  WIDTH  signed remainder; holds until the next completion
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when results become valid
- div_by_zero  output  1  flag qualified by done: B was 0

Behaviour:
- Reset: on a clock edge with reset=1, state returns to IDLE, regardless of state.
  - All outputs go to 0: quotient, remainder, busy, done, div_by_zero.
  - Reset during RUN aborts the operation. No done is produced.
- States: IDLE, RUN, FINISH.
- IDLE:
  - On an edge with start=1, latch the following and go to RUN:
    - sign_q = A[W-1] ^ B[W-1]
    - sign_r = A[W-1]
    - zero flag = (B == 0)
    - |A| and |B| as WIDTH-bit unsigned magnitudes, where |−2^(W-1)| = 2^(W-1)
    - clear the partial remainder (WIDTH+1 bits) and the iteration counter
  - start=0 keeps the block in IDLE.
- RUN, one iteration per edge, MSB first:
  - Shift the partial remainder left by 1 and bring in the next dividend magnitude bit.
  - Trial-subtract the divisor magnitude, WIDTH+1 bits wide.
  - If the result is non-negative, keep it and shift in quotient bit 1. Otherwise restore and shift in 0.
  - After WIDTH iterations, go to FINISH.
- FINISH, one edge:
  - Write quotient = sign_q ? −q_mag : q_mag, and remainder = sign_r ? −r_mag : r_mag. Negation is modulo 2^WIDTH.
  - Assert done for exactly 1 cycle, drop busy, return to IDLE.
- Latency: if start is sampled at edge 0, done is high in the cycle after edge WIDTH+1 (edge 33 for WIDTH=32). Latency is the same for every operand value, including B=0.
- busy = 1 in RUN and FINISH; it falls in the same cycle done rises.
- start while busy is ignored. It is not queued, and the operands in flight are unaffected.
- start on the cycle done is high is accepted: the FSM is already in IDLE.
- A and B may change after the accepting edge without effect.
- Division by zero:
  - quotient = all ones (−1), remainder = A unmodified.
  - div_by_zero = 1 in the done cycle and held until the next completion. Otherwise it is 0.
- Overflow: −2^(W-1) / −1 gives quotient 0x80000000 and remainder 0. No flag is raised. This falls out naturally from magnitude arithmetic.
- Sign rule: the remainder takes the sign of the dividend (or is 0). In all non-zero-divisor cases, A = quotient*B + remainder holds modulo 2^WIDTH.
- quotient and remainder change only on the FINISH edge or on reset.

Test Plan:
- Unsigned-range divide: start with A=100, B=7 → done pulses exactly 33 cycles after start; quotient=14, remainder=2, div_by_zero=0, busy low with done.
- Signed divides:
  - A=−100, B=7 → quotient=−14 (0xFFFFFFF2), remainder=−2 (0xFFFFFFFE).
  - A=100, B=−7 → quotient=−14, remainder=2.
  - A=−100, B=−7 → quotient=14, remainder=−2.
- Corner values:
  - A=0x80000000, B=0xFFFFFFFF → quotient=0x80000000, remainder=0.
  - A=0x7FFFFFFF, B=1 → quotient=0x7FFFFFFF, remainder=0.
  - A=5, B=9 → quotient=0, remainder=5.
- Divide by zero: A=1234, B=0 → same 33-cycle latency; quotient=0xFFFFFFFF, remainder=1234, div_by_zero=1; next valid divide clears the flag.
- Handshake: start re-pulsed with different operands 5 cycles into RUN → ignored, and the original result is returned. start on the done cycle → second result arrives 33 cycles later. Outputs hold between operations.
- Reset mid-operation: reset at cycle 10 of RUN → next cycle all outputs 0, no done pulse. A fresh start afterwards yields the correct result (A=100, B=7 → 14, 2).
